key_filter_pulse: RTL and testbench

- Debounces a raw, active-low mechanical push-button input.
- Emits exactly one single-cycle pulse per confirmed press.
- Sits directly upstream of the 4-bit counter stage: key_flag drives that stage's en input, so each physical press triggers one counter run.
- Also exports the debounced key level for status or LED use.

---
 rtl/key_filter_pulse.sv | 123 ++++++++++++
 tb/tb_key_filter_pulse.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_filter_pulse.sv
// Purpose: debounce an active-low push button; one-cycle key_flag per confirmed press, plus debounced level.
// Latency: key_flag/key_state change CNT_MAX+4 rising edges after key_in is first sampled at its new stable level.
// Backpressure: none; free-running, the downstream stage must accept key_flag whenever it pulses.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   key_in    - raw button level (0 = pressed), asynchronous, may bounce
//   key_flag  - registered one-cycle pulse on each confirmed press
//   key_state - registered debounced level (1 = released, 0 = pressed)
`timescale 1ns/1ps
module key_filter_pulse #(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic s0, s1, s2;
  logic nedge, pedge;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_flag_nxt;
  logic             key_state_nxt;

  // s0/s1 resolve metastability; s2 is the previous synchronised level.
  // Resetting all three high means a key held low across reset release
  // shows up as a press edge and is filtered like any other press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s0 <= key_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign nedge = s2 & ~s1;
  assign pedge = ~s2 & s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_flag  <= key_flag_nxt;
      key_state <= key_state_nxt;
    end
  end

  // Edges are tested before the terminal count so that an edge arriving on
  // the last count cycle aborts the filter rather than confirming it.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    key_flag_nxt  = 1'b0;
    key_state_nxt = key_state;

    unique case (state)
      IDLE: begin
        if (nedge) begin
          state_nxt = FILTER_DOWN;
        end
      end

      FILTER_DOWN: begin
        if (pedge) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = DOWN;
          key_flag_nxt  = 1'b1;
          key_state_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DOWN: begin
        if (pedge) begin
          state_nxt = FILTER_UP;
        end
      end

      FILTER_UP: begin
        if (nedge) begin
          state_nxt = DOWN;
        end else if (cnt == CNT_LAST) begin
          // Release is reported only through the level; no pulse.
          state_nxt     = IDLE;
          key_state_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_filter_pulse.sv
`timescale 1ns/1ps
module tb_key_filter_pulse;

  logic clk;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;

  int total;
  int bad;

  key_filter_pulse #(
    .CNT_MAX(9),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reset held 5 cycles, then 20 idle cycles with the key released.
  task automatic test_reset();
    rst_n  = 1'b0;
    key_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (key_flag !== 1'b0 || key_state !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold cyc %0d flag=%b state=%b want flag=0 state=1", i, key_flag, key_state);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (key_flag !== 1'b0 || key_state !== 1'b1) begin
        bad++;
        $display("FAIL reset_idle cyc %0d flag=%b state=%b want flag=0 state=1", i, key_flag, key_state);
      end
    end
  endtask

  // Clean press: flag exactly on edge 13 after the first low sample.
  task automatic test_clean_press();
    logic ef, es;
    @(negedge clk);
    key_in = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      ef = (i == 13);
      es = (i >= 13) ? 1'b0 : 1'b1;
      total++;
      if (key_flag !== ef || key_state !== es) begin
        bad++;
        $display("FAIL clean_press edge %0d flag=%b state=%b want flag=%b state=%b", i, key_flag, key_state, ef, es);
      end
    end
  endtask

  // Clean release: level returns on edge 13, never a pulse.
  task automatic test_clean_release();
    logic es;
    @(negedge clk);
    key_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      es = (i >= 13) ? 1'b1 : 1'b0;
      total++;
      if (key_flag !== 1'b0 || key_state !== es) begin
        bad++;
        $display("FAIL clean_release edge %0d flag=%b state=%b want flag=0 state=%b", i, key_flag, key_state, es);
      end
    end
  endtask

  // Five toggles 0/1/0/1/0 every 3 cycles, then held low.
  task automatic test_bouncy_press();
    logic ef, es;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      key_in = t[0];
      for (int i = 1; i <= 3; i++) begin
        @(posedge clk); #1;
        total++;
        if (key_flag !== 1'b0 || key_state !== 1'b1) begin
          bad++;
          $display("FAIL bouncy_press_bounce seg %0d cyc %0d flag=%b state=%b want flag=0 state=1", t, i, key_flag, key_state);
        end
      end
    end
    @(negedge clk);
    key_in = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      ef = (i == 13);
      es = (i >= 13) ? 1'b0 : 1'b1;
      total++;
      if (key_flag !== ef || key_state !== es) begin
        bad++;
        $display("FAIL bouncy_press edge %0d flag=%b state=%b want flag=%b state=%b", i, key_flag, key_state, ef, es);
      end
    end
  endtask

  // From DOWN: 1/0/1/0 every 3 cycles, then held high.
  task automatic test_release_bounce();
    logic es;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      key_in = ~t[0];
      for (int i = 1; i <= 3; i++) begin
        @(posedge clk); #1;
        total++;
        if (key_flag !== 1'b0 || key_state !== 1'b0) begin
          bad++;
          $display("FAIL release_bounce seg %0d cyc %0d flag=%b state=%b want flag=0 state=0", t, i, key_flag, key_state);
        end
      end
    end
    @(negedge clk);
    key_in = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      es = (i >= 13) ? 1'b1 : 1'b0;
      total++;
      if (key_flag !== 1'b0 || key_state !== es) begin
        bad++;
        $display("FAIL release_final edge %0d flag=%b state=%b want flag=0 state=%b", i, key_flag, key_state, es);
      end
    end
  endtask

  // 5-cycle low glitch must be rejected.
  task automatic test_glitch();
    @(negedge clk);
    key_in = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        @(negedge clk);
        key_in = 1'b1;
      end
      total++;
      if (key_flag !== 1'b0 || key_state !== 1'b1) begin
        bad++;
        $display("FAIL glitch cyc %0d flag=%b state=%b want flag=0 state=1", i, key_flag, key_state);
      end
    end
  endtask

  // Reset at cnt=5 in FILTER_DOWN, then release with key still low.
  task automatic test_reset_mid_filter();
    logic ef, es;
    @(negedge clk);
    key_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      total++;
      if (key_flag !== 1'b0 || key_state !== 1'b1) begin
        bad++;
        $display("FAIL mid_prefilter cyc %0d flag=%b state=%b want flag=0 state=1", i, key_flag, key_state);
      end
    end
    total++;
    if (dut.cnt !== 4'd5) begin
      bad++;
      $display("FAIL mid_cnt_before cnt=%0d want 5", dut.cnt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (key_flag !== 1'b0 || key_state !== 1'b1 || dut.cnt !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset_now flag=%b state=%b cnt=%0d want flag=0 state=1 cnt=0", key_flag, key_state, dut.cnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      ef = (i == 13);
      es = (i >= 13) ? 1'b0 : 1'b1;
      total++;
      if (key_flag !== ef || key_state !== es) begin
        bad++;
        $display("FAIL post_reset_press edge %0d flag=%b state=%b want flag=%b state=%b", i, key_flag, key_state, ef, es);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    key_in = 1'b1;
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bouncy_press();
    test_release_bounce();
    test_glitch();
    test_reset_mid_filter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
